mult_datapath: RTL
==================

Name: mult_datapath

Overview:
- Register/arithmetic datapath for the signed shift-add multiplier. It consumes Ld_A, Ld_B and Shift_En from the multiplier control FSM.
- Holds the multiplicand M, the accumulator A, the multiplier/low-product register B and the sign-extension bit X.
- Performs one combined add-then-arithmetic-shift step per Shift_En cycle. The full signed product {A,B} is ready after WIDTH steps.
- Sits directly downstream of the control FSM. Its outputs drive the hex displays / LEDs.

Parameters:
- WIDTH, 8, operand width in bits. A, B and M are each WIDTH bits; the product is 2*WIDTH bits.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Din  input  WIDTH  operand from switches (two's complement).
- Ld_A  input  1  load multiplicand: M<=Din, clear A, X, step count.
- Ld_B  input  1  load multiplier: B<=Din, clear A, X, step count.
- Shift_En  input  1  perform one add-shift step.
- Aval  output  WIDTH  A register (upper product half).
- Bval  output  WIDTH  B register (lower product half).
- Xval  output  1  X (sign-extension) bit.
- Done  output  1  high when WIDTH steps have completed since the last load.

Behaviour:
- Reset:
  - Reset_n low clears M, A, B, X and cnt to 0 and sets Done to 0, asynchronously, regardless of Clk.
  - Reset mid-multiplication aborts the operation. All state is 0 after release.
- Step counter:
  - cnt is $clog2(WIDTH+1) bits.
  - Done = (cnt == WIDTH) AND (a load has occurred since reset).
  - Implement this with a 1-bit "loaded" flag, set by Ld_A or Ld_B and cleared by reset.
- Priority each cycle: Ld_A / Ld_B > Shift_En.
  - Ld_A and Ld_B together: both M and B load from Din; A, X and cnt clear.
  - Any load with Shift_En in the same cycle: the load wins and no step occurs.
- Step rules:
  - A step happens when Shift_En=1, no load is active, loaded=1 and cnt<WIDTH.
  - Otherwise Shift_En is ignored and all registers hold. This covers before any load and after Done.
- Step arithmetic (k = cnt value before the step, single cycle):
  - If B[0]=1: S = {A[W-1],A} + {M[W-1],M} when k<WIDTH-1, or {A[W-1],A} - {M[W-1],M} when k==WIDTH-1. The subtraction is (WIDTH+1)-bit two's complement, and the carry-out beyond WIDTH+1 bits is discarded.
  - If B[0]=0: S = {X,A}.
  - Next-state values:
    - X <= S[W]
    - A <= {S[W], S[W-1:1]}
    - B <= {S[0], B[W-1:1]}
    - cnt <= cnt+1
- Latency:
  - Result is valid in {Aval,Bval} on the rising edge of Done, exactly WIDTH accepted steps after the last load.
  - The control supplies WIDTH consecutive Shift_En cycles. Gaps in Shift_En only stretch the latency; the result is unchanged.
- Stability: outputs are direct register values (no combinational path from inputs to outputs). They hold indefinitely after Done until the next load or reset.
- Re-run: a new multiplication requires a load. A load with Done=1 clears Done on the next edge.

Test Plan:
- Reset_n=0 mid-run (after 3 steps of 7*5), release, then apply Shift_En x8 -> all outputs 0, Done=0, no register changes.
- Ld_A with Din=0x07, Ld_B with Din=0x05, Shift_En x8 -> Aval=0x00, Bval=0x23, Xval=0, Done=1 after the 8th step.
- M=0xFD (-3), B=0x05, 8 steps -> {Aval,Bval}=0xFFF1, Xval=1; then M=0x05, B=0xFD, 8 steps -> 0xFFF1 (last-step subtract path).
- M=0x80, B=0x80, 8 steps -> {Aval,Bval}=0x4000, Xval=0; M=0x7F, B=0x80 -> 0xC080.
- After Done, Shift_En x4 -> outputs unchanged. Ld_B (Din=0x02) asserted together with Shift_En -> B=0x02, A=0, cnt=0, Done=0, no step taken.
- Shift_En with gaps (1 on, 2 off, repeated) for 7*5 -> same 0x0023 result, Done only after the 8th accepted step.

Source files
------------

// File: rtl/mult_datapath.sv
// Register datapath of the signed shift-add multiplier: holds M, A, B and X and performs
// one add/subtract-then-arithmetic-shift step per accepted Shift_En. Product {A,B} is ready WIDTH steps after a load.
module mult_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] Din,
   input  logic             Ld_A,
   input  logic             Ld_B,
   input  logic             Shift_En,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             Xval,
   output logic             Done
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             x_q, x_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             loaded_q, loaded_d;

   logic             load;
   logic             step_ok;
   logic             last_step;
   logic [WIDTH:0]   a_ext;
   logic [WIDTH:0]   m_ext;
   logic [WIDTH:0]   sum;

   assign load      = Ld_A | Ld_B;
   assign last_step = (cnt_q == CW'(WIDTH - 1));
   assign step_ok   = Shift_En & ~load & loaded_q & (cnt_q < CW'(WIDTH));
   assign a_ext     = {a_q[WIDTH-1], a_q};
   assign m_ext     = {m_q[WIDTH-1], m_q};

   // The final partial product carries the multiplier's sign weight, so it is subtracted.
   always_comb begin
      sum = {x_q, a_q};
      if (b_q[0]) begin
         if (last_step) begin
            sum = a_ext - m_ext;
         end else begin
            sum = a_ext + m_ext;
         end
      end
   end

   always_comb begin
      m_d      = m_q;
      a_d      = a_q;
      b_d      = b_q;
      x_d      = x_q;
      cnt_d    = cnt_q;
      loaded_d = loaded_q;
      if (load) begin
         if (Ld_A) begin
            m_d = Din;
         end
         if (Ld_B) begin
            b_d = Din;
         end
         a_d      = '0;
         x_d      = 1'b0;
         cnt_d    = '0;
         loaded_d = 1'b1;
      end else if (step_ok) begin
         x_d   = sum[WIDTH];
         a_d   = {sum[WIDTH], sum[WIDTH-1:1]};
         b_d   = {sum[0], b_q[WIDTH-1:1]};
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         m_q      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         x_q      <= 1'b0;
         cnt_q    <= '0;
         loaded_q <= 1'b0;
      end else begin
         m_q      <= m_d;
         a_q      <= a_d;
         b_q      <= b_d;
         x_q      <= x_d;
         cnt_q    <= cnt_d;
         loaded_q <= loaded_d;
      end
   end

   // Done is decoded only from registers, so there is no input-to-output path.
   assign Aval = a_q;
   assign Bval = b_q;
   assign Xval = x_q;
   assign Done = loaded_q & (cnt_q == CW'(WIDTH));

endmodule
